// File: rtl/global_buffer_bram_2p.sv
// Two-port operand buffer: one write port, one read port, byte enables, write-first forwarding, optional auto-increment pointers.
// Read latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); no backpressure, a result is delivered every cycle a read was issued.
module global_buffer_bram_2p #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int OUT_REG   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_BITS/8-1:0] wr_be,
  input  logic                   wr_auto,
  input  logic [ADDR_BITS-1:0]   wr_index,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   rd_en,
  input  logic                   rd_auto,
  input  logic [ADDR_BITS-1:0]   rd_index,
  input  logic                   ptr_clr,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   rd_valid,
  output logic [ADDR_BITS-1:0]   wr_ptr,
  output logic [ADDR_BITS-1:0]   rd_ptr
);

  localparam int LANES = DATA_BITS / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] waddr;
  logic [ADDR_BITS-1:0] raddr;
  logic [DATA_BITS-1:0] be_mask;
  logic [DATA_BITS-1:0] ram_q;
  logic [DATA_BITS-1:0] fwd_mask;
  logic [DATA_BITS-1:0] fwd_dat;
  logic [DATA_BITS-1:0] s1_dat;
  logic                 s1_vld;

  assign waddr = wr_auto ? wr_ptr : wr_index;
  assign raddr = rd_auto ? rd_ptr : rd_index;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      be_mask[8*i +: 8] = {8{wr_be[i]}};
    end
  end

  // Storage kept free of reset so it maps onto block RAM byte-write primitives.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem[waddr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // RAM returns old contents on a collision; the captured lane mask patches in the new bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q    <= '0;
      fwd_mask <= '0;
      fwd_dat  <= '0;
      s1_vld   <= 1'b0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) begin
        ram_q    <= mem[raddr];
        fwd_mask <= (wr_en && (waddr == raddr)) ? be_mask : '0;
        fwd_dat  <= wr_data;
      end
    end
  end

  assign s1_dat = (ram_q & ~fwd_mask) | (fwd_dat & fwd_mask);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= s1_vld;
          if (s1_vld) begin
            rd_data <= s1_dat;
          end
        end
      end
    end else begin : g_no_out_reg
      assign rd_data  = s1_dat;
      assign rd_valid = s1_vld;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || ptr_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && wr_auto) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      if (rd_en && rd_auto) begin
        rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_global_buffer_bram_2p.sv
// Bench for global_buffer_bram_2p: two instances (latency 1 and latency 2) share all inputs.
module tb_global_buffer_bram_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic        wr_auto;
  logic [3:0]  wr_index;
  logic [31:0] wr_data;
  logic        rd_en;
  logic        rd_auto;
  logic [3:0]  rd_index;
  logic        ptr_clr;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [3:0]  wr_ptr0, wr_ptr1, rd_ptr0, rd_ptr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  global_buffer_bram_2p #(.ADDR_BITS(4), .DATA_BITS(32), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_auto(wr_auto),
    .wr_index(wr_index), .wr_data(wr_data), .rd_en(rd_en), .rd_auto(rd_auto),
    .rd_index(rd_index), .ptr_clr(ptr_clr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .wr_ptr(wr_ptr0), .rd_ptr(rd_ptr0)
  );

  global_buffer_bram_2p #(.ADDR_BITS(4), .DATA_BITS(32), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_auto(wr_auto),
    .wr_index(wr_index), .wr_data(wr_data), .rd_en(rd_en), .rd_auto(rd_auto),
    .rd_index(rd_index), .ptr_clr(ptr_clr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_ptr(wr_ptr1), .rd_ptr(rd_ptr1)
  );

  typedef struct {
    logic        wen;
    logic [3:0]  be;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ren;
    logic [3:0]  ra;
    logic        ev0;
    logic [31:0] ed0;
    logic        ev1;
    logic [31:0] ed1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_be = 4'h0; wr_auto = 0; wr_index = 0; wr_data = 0;
    rd_en = 0; rd_auto = 0; rd_index = 0; ptr_clr = 0;
  endtask

  initial begin
    logic [31:0] exp_mem [16];

    vecs[0]  = '{1, 4'hF, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 4'h0, 0, 32'h0,        1, 5, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[2]  = '{0, 4'h0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF};
    vecs[3]  = '{1, 4'h5, 5, 32'h11223344, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[4]  = '{0, 4'h0, 0, 32'h0,        1, 5, 1, 32'hDE22BE44, 0, 32'hDEADBEEF};
    vecs[5]  = '{1, 4'hF, 9, 32'hAAAAAAAA, 0, 0, 0, 32'hDE22BE44, 1, 32'hDE22BE44};
    vecs[6]  = '{1, 4'h3, 9, 32'h12345678, 1, 9, 1, 32'hAAAA5678, 0, 32'hDE22BE44};
    vecs[7]  = '{0, 4'h0, 0, 32'h0,        1, 9, 1, 32'hAAAA5678, 1, 32'hAAAA5678};
    vecs[8]  = '{1, 4'h0, 9, 32'hFFFFFFFF, 1, 9, 1, 32'hAAAA5678, 1, 32'hAAAA5678};
    vecs[9]  = '{0, 4'h0, 0, 32'h0,        1, 5, 1, 32'hDE22BE44, 1, 32'hAAAA5678};
    vecs[10] = '{0, 4'h0, 0, 32'h0,        0, 0, 0, 32'hDE22BE44, 1, 32'hDE22BE44};
    vecs[11] = '{0, 4'h0, 0, 32'h0,        0, 0, 0, 32'hDE22BE44, 0, 32'hDE22BE44};

    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("reset rd_valid0", 32'(rd_valid0), 32'h0);
    chk("reset rd_valid1", 32'(rd_valid1), 32'h0);
    chk("reset rd_data0", rd_data0, 32'h0);
    chk("reset rd_data1", rd_data1, 32'h0);
    chk("reset wr_ptr", 32'(wr_ptr0), 32'h0);
    chk("reset rd_ptr", 32'(rd_ptr1), 32'h0);

    // Directed explicit-address vectors: latency, byte enables, forwarding, hold
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].wen; wr_be = vecs[i].be; wr_index = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].ren; rd_index = vecs[i].ra;
      tick();
      chk($sformatf("vec%0d rd_valid0", i), 32'(rd_valid0), 32'(vecs[i].ev0));
      chk($sformatf("vec%0d rd_data0", i), rd_data0, vecs[i].ed0);
      chk($sformatf("vec%0d rd_valid1", i), 32'(rd_valid1), 32'(vecs[i].ev1));
      chk($sformatf("vec%0d rd_data1", i), rd_data1, vecs[i].ed1);
    end
    idle();
    chk("explicit wr_ptr unmoved", 32'(wr_ptr0), 32'h0);
    chk("explicit rd_ptr unmoved", 32'(rd_ptr0), 32'h0);

    // Streaming writes with wrap
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("stream wr_ptr k=%0d", k), 32'(wr_ptr0), 32'(k % 16));
      wr_en = 1; wr_auto = 1; wr_be = 4'hF; wr_data = 32'(k);
      exp_mem[k % 16] = 32'(k);
      tick();
    end
    idle();
    chk("stream wr_ptr end", 32'(wr_ptr1), 32'd2);
    chk("stream rd_ptr still", 32'(rd_ptr0), 32'd0);

    // 16 back-to-back auto reads
    for (int k = 0; k < 16; k++) begin
      rd_en = 1; rd_auto = 1;
      tick();
      chk($sformatf("stream rd_valid0 k=%0d", k), 32'(rd_valid0), 32'h1);
      chk($sformatf("stream rd_data0 k=%0d", k), rd_data0, exp_mem[k]);
      if (k > 0) begin
        chk($sformatf("stream rd_valid1 k=%0d", k), 32'(rd_valid1), 32'h1);
        chk($sformatf("stream rd_data1 k=%0d", k), rd_data1, exp_mem[k-1]);
      end
    end
    idle();
    tick();
    chk("stream rd_valid0 stop", 32'(rd_valid0), 32'h0);
    chk("stream last rd_data1", rd_data1, 32'd15);
    chk("stream rd_ptr wrapped", 32'(rd_ptr0), 32'd0);

    // Bring wr_ptr to 7 and rd_ptr to 3, then clear with a simultaneous auto write
    for (int k = 0; k < 5; k++) begin
      wr_en = 1; wr_auto = 1; wr_be = 4'hF; wr_data = 32'h100 + 32'(k);
      rd_en = (k < 3); rd_auto = 1;
      tick();
    end
    idle();
    chk("pre-clear wr_ptr", 32'(wr_ptr0), 32'd7);
    chk("pre-clear rd_ptr", 32'(rd_ptr0), 32'd3);
    wr_en = 1; wr_auto = 1; wr_be = 4'hF; wr_data = 32'h77; ptr_clr = 1;
    tick();
    idle();
    chk("ptr_clr wr_ptr", 32'(wr_ptr0), 32'd0);
    chk("ptr_clr rd_ptr", 32'(rd_ptr1), 32'd0);
    rd_en = 1; rd_index = 4'd7;
    tick();
    idle();
    chk("ptr_clr data at 7", rd_data0, 32'h77);
    tick();
    tick();

    // Reset with reads in flight; a write during reset must be dropped
    rd_en = 1; rd_index = 4'd7;
    tick();
    chk("mid rd_valid0 a", 32'(rd_valid0), 32'h1);
    rd_index = 4'd2;
    tick();
    chk("mid rd_valid1 a", 32'(rd_valid1), 32'h1);
    idle();
    rst = 1; wr_en = 1; wr_be = 4'hF; wr_index = 4'd7; wr_data = 32'hBAD0BAD0;
    tick();
    idle();
    rst = 0;
    chk("rst rd_valid0", 32'(rd_valid0), 32'h0);
    chk("rst rd_valid1", 32'(rd_valid1), 32'h0);
    chk("rst rd_data0", rd_data0, 32'h0);
    chk("rst rd_data1", rd_data1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-rst rd_valid1 c%0d", k), 32'(rd_valid1), 32'h0);
      chk($sformatf("post-rst rd_data1 c%0d", k), rd_data1, 32'h0);
      chk($sformatf("post-rst rd_valid0 c%0d", k), 32'(rd_valid0), 32'h0);
    end
    rd_en = 1; rd_index = 4'd7;
    tick();
    idle();
    chk("mem intact 7 dut0", rd_data0, 32'h77);
    tick();
    chk("mem intact 7 dut1", rd_data1, 32'h77);
    chk("mem intact 7 vld1", 32'(rd_valid1), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
